// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/stall sequencer for the multi-cycle mul/div unit.
// One start pulse per M op, stall until ready, drain results of flushed ops.
module md_issue_ctrl #(
  parameter int DATA_BITS = 32,
  parameter int CTRL_BITS = 5,
  parameter int TIMEOUT   = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   ex_is_md,
  input  logic [CTRL_BITS-1:0]   ex_ctrl,
  input  logic                   flush,
  input  logic                   md_ready,
  input  logic [2*DATA_BITS-1:0] md_out,
  output logic                   md_valid,
  output logic [CTRL_BITS-1:0]   md_ctrl,
  output logic                   stall,
  output logic                   res_valid,
  output logic [2*DATA_BITS-1:0] res_data,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int CW = 6;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]             r_state;
  logic [1:0]             w_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CTRL_BITS-1:0]   r_md_ctrl;
  logic [2*DATA_BITS-1:0] r_res_data;
  logic                   r_timeout_err;

  logic w_req;
  logic w_idle;
  logic w_wait;
  logic w_done;
  logic w_drain;
  logic w_to;
  logic w_latch;

  assign w_req   = ex_valid & ex_is_md & ~flush;
  assign w_idle  = (r_state == IDLE);
  assign w_wait  = (r_state == WAIT);
  assign w_done  = (r_state == DONE);
  assign w_drain = (r_state == DRAIN);

  // unit gave no answer by the last allowed waiting cycle
  assign w_to    = (w_wait | w_drain) & ~md_ready
                 & (r_cnt == CNT_LAST);
  assign w_latch = w_wait & md_ready & ~flush;

  // next-state decode; a flushed op's result is dropped, never retired
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req)
          w_nxt = WAIT;
      end
      WAIT: begin
        if (md_ready)
          w_nxt = flush ? IDLE : DONE;
        else if (w_to)
          w_nxt = IDLE;
        else if (flush)
          w_nxt = DRAIN;
      end
      DONE: begin
        w_nxt = IDLE;
      end
      DRAIN: begin
        if (md_ready | w_to)
          w_nxt = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_nxt;
  end

  // wait counter: cleared at issue, counts while the unit is occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_idle & w_req)
      r_cnt <= '0;
    else if (w_wait | w_drain)
      r_cnt <= r_cnt + CW'(1);
  end

  // control code captured at issue, held for the result select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_md_ctrl <= '0;
    else if (w_idle & w_req)
      r_md_ctrl <= ex_ctrl;
  end

  // result word held until the next accepted completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_res_data <= '0;
    else if (w_latch)
      r_res_data <= md_out;
  end

  // sticky hang flag, only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_timeout_err <= 1'b0;
    else if (w_to)
      r_timeout_err <= 1'b1;
  end

  assign md_valid    = rst_n & w_idle & w_req;
  assign stall       = rst_n & ((w_idle & w_req) | w_wait
                     | (w_drain & ex_valid & ex_is_md));
  assign res_valid   = rst_n & w_done;
  assign busy        = rst_n & (w_wait | w_drain);
  assign md_ctrl     = r_md_ctrl;
  assign res_data    = r_res_data;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: scenario bench for md_issue_ctrl.
// Expected values come from cycle arithmetic on the issue/latency rules.
module tb_md_issue_ctrl;

  localparam int DB = 32;
  localparam int CB = 5;
  localparam int TO = 40;
  localparam int LAT = 33;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_is_md;
  logic [CB-1:0] ex_ctrl;
  logic          flush;
  logic          md_ready;
  logic [2*DB-1:0] md_out;
  logic          md_valid;
  logic [CB-1:0] md_ctrl;
  logic          stall;
  logic          res_valid;
  logic [2*DB-1:0] res_data;
  logic          busy;
  logic          timeout_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [2*DB-1:0] exp_res = '0;

  md_issue_ctrl #(
    .DATA_BITS(DB), .CTRL_BITS(CB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_is_md(ex_is_md),
    .ex_ctrl(ex_ctrl), .flush(flush),
    .md_ready(md_ready), .md_out(md_out),
    .md_valid(md_valid), .md_ctrl(md_ctrl),
    .stall(stall), .res_valid(res_valid),
    .res_data(res_data), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    ex_valid = 1'b0;
    ex_is_md = 1'b0;
    ex_ctrl  = CB'($urandom);
    flush    = 1'b0;
    md_ready = 1'b0;
    md_out   = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    ex_valid = 1'b1;
    ex_is_md = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({md_valid, stall, res_valid, busy} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset outs k=%0d got %b exp 0000", k,
                 {md_valid, stall, res_valid, busy});
      end
      n_chk++;
      if ({res_data, md_ctrl, timeout_err} !== '0) begin
        n_fail++;
        $display("FAIL reset regs got %h/%h/%b exp 0", res_data,
                 md_ctrl, timeout_err);
      end
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    set_idle();
  endtask

  task automatic test_single();
    logic [CB-1:0] ctl;
    logic [2*DB-1:0] d;
    logic [3:0] ev;
    ctl = CB'($urandom);
    d = {$urandom, $urandom};
    for (int c = 0; c <= 35; c++) begin
      @(negedge clk);
      set_idle();
      if (c <= 34) begin
        ex_valid = 1'b1; ex_is_md = 1'b1; ex_ctrl = ctl;
      end
      if (c == LAT) begin md_ready = 1'b1; md_out = d; end
      #1;
      ev = {c == 0, c <= 33, c == 34, c >= 1 && c <= 33};
      n_chk++;
      if ({md_valid, stall, res_valid, busy} !== ev) begin
        n_fail++;
        $display("FAIL single v/s/r/b c=%0d got %b exp %b", c,
                 {md_valid, stall, res_valid, busy}, ev);
      end
      if (c >= 1) begin
        n_chk++;
        if (md_ctrl !== ctl) begin
          n_fail++;
          $display("FAIL single md_ctrl c=%0d got %h exp %h", c,
                   md_ctrl, ctl);
        end
      end
      n_chk++;
      if (res_data !== (c >= 34 ? d : exp_res)) begin
        n_fail++;
        $display("FAIL single res_data c=%0d got %h exp %h", c,
                 res_data, (c >= 34 ? d : exp_res));
      end
    end
    exp_res = d;
  endtask

  task automatic test_back_to_back();
    logic [CB-1:0] c1, c2;
    logic [2*DB-1:0] d1, d2, er;
    logic [3:0] ev;
    c1 = CB'($urandom);
    c2 = c1 ^ CB'($urandom_range(1, 31));
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    for (int c = 0; c <= 70; c++) begin
      @(negedge clk);
      set_idle();
      ex_valid = (c <= 69);
      ex_is_md = 1'b1;
      ex_ctrl  = (c <= 34) ? c1 : c2;
      if (c == LAT) begin md_ready = 1'b1; md_out = d1; end
      if (c == 35 + LAT) begin md_ready = 1'b1; md_out = d2; end
      #1;
      ev = {c == 0 || c == 35,
            c <= 33 || (c >= 35 && c <= 68),
            c == 34 || c == 69,
            (c >= 1 && c <= 33) || (c >= 36 && c <= 68)};
      n_chk++;
      if ({md_valid, stall, res_valid, busy} !== ev) begin
        n_fail++;
        $display("FAIL b2b v/s/r/b c=%0d got %b exp %b", c,
                 {md_valid, stall, res_valid, busy}, ev);
      end
      if (c >= 1) begin
        n_chk++;
        if (md_ctrl !== (c <= 35 ? c1 : c2)) begin
          n_fail++;
          $display("FAIL b2b md_ctrl c=%0d got %h exp %h", c,
                   md_ctrl, (c <= 35 ? c1 : c2));
        end
      end
      er = (c < 34) ? exp_res : (c < 69) ? d1 : d2;
      n_chk++;
      if (res_data !== er) begin
        n_fail++;
        $display("FAIL b2b res_data c=%0d got %h exp %h", c,
                 res_data, er);
      end
    end
    exp_res = d2;
  endtask

  task automatic test_flush_nonmd();
    int f;
    logic [CB-1:0] ctl;
    logic [3:0] ev;
    f = $urandom_range(2, 30);
    ctl = CB'($urandom);
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      set_idle();
      if (c <= f) begin
        ex_valid = 1'b1; ex_is_md = 1'b1; ex_ctrl = ctl;
      end else begin
        ex_valid = 1'($urandom);
      end
      flush = (c == f);
      md_ready = (c == LAT);
      #1;
      ev = {c == 0, c <= f, 1'b0, c >= 1 && c <= 33};
      n_chk++;
      if ({md_valid, stall, res_valid, busy} !== ev) begin
        n_fail++;
        $display("FAIL flush_add v/s/r/b f=%0d c=%0d got %b exp %b",
                 f, c, {md_valid, stall, res_valid, busy}, ev);
      end
      n_chk++;
      if (res_data !== exp_res) begin
        n_fail++;
        $display("FAIL flush_add res_data c=%0d got %h exp %h", c,
                 res_data, exp_res);
      end
    end
  endtask

  task automatic test_flush_md();
    int f;
    logic [CB-1:0] c1, c2;
    logic [2*DB-1:0] d2;
    logic [3:0] ev;
    f = $urandom_range(2, 30);
    c1 = CB'($urandom);
    c2 = c1 ^ CB'($urandom_range(1, 31));
    d2 = {$urandom, $urandom};
    for (int c = 0; c <= 69; c++) begin
      @(negedge clk);
      set_idle();
      ex_valid = (c <= 68);
      ex_is_md = 1'b1;
      ex_ctrl  = (c <= f) ? c1 : c2;
      flush    = (c == f);
      if (c == LAT) md_ready = 1'b1;
      if (c == 34 + LAT) begin md_ready = 1'b1; md_out = d2; end
      #1;
      ev = {c == 0 || c == 34, c <= 67, c == 68,
            (c >= 1 && c <= 33) || (c >= 35 && c <= 67)};
      n_chk++;
      if ({md_valid, stall, res_valid, busy} !== ev) begin
        n_fail++;
        $display("FAIL flush_rem v/s/r/b f=%0d c=%0d got %b exp %b",
                 f, c, {md_valid, stall, res_valid, busy}, ev);
      end
      if (c >= 1) begin
        n_chk++;
        if (md_ctrl !== (c <= 34 ? c1 : c2)) begin
          n_fail++;
          $display("FAIL flush_rem md_ctrl c=%0d got %h exp %h", c,
                   md_ctrl, (c <= 34 ? c1 : c2));
        end
      end
      n_chk++;
      if (res_data !== (c >= 68 ? d2 : exp_res)) begin
        n_fail++;
        $display("FAIL flush_rem res_data c=%0d got %h exp %h", c,
                 res_data, (c >= 68 ? d2 : exp_res));
      end
    end
    exp_res = d2;
  endtask

  task automatic test_flush_ready();
    logic [3:0] ev;
    for (int c = 0; c <= 35; c++) begin
      @(negedge clk);
      set_idle();
      if (c <= LAT) begin ex_valid = 1'b1; ex_is_md = 1'b1; end
      flush = (c == LAT);
      md_ready = (c == LAT);
      #1;
      ev = {c == 0, c <= 33, 1'b0, c >= 1 && c <= 33};
      n_chk++;
      if ({md_valid, stall, res_valid, busy} !== ev) begin
        n_fail++;
        $display("FAIL flush_ready v/s/r/b c=%0d got %b exp %b", c,
                 {md_valid, stall, res_valid, busy}, ev);
      end
      n_chk++;
      if (res_data !== exp_res) begin
        n_fail++;
        $display("FAIL flush_ready res_data c=%0d got %h exp %h", c,
                 res_data, exp_res);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] ev;
    for (int c = 0; c <= TO + 8; c++) begin
      @(negedge clk);
      set_idle();
      if (c <= TO) begin ex_valid = 1'b1; ex_is_md = 1'b1; end
      else ex_valid = 1'($urandom);
      #1;
      ev = {c == 0, c <= TO, 1'b0, c >= 1 && c <= TO};
      n_chk++;
      if ({md_valid, stall, res_valid, busy} !== ev) begin
        n_fail++;
        $display("FAIL timeout v/s/r/b c=%0d got %b exp %b", c,
                 {md_valid, stall, res_valid, busy}, ev);
      end
      n_chk++;
      if (timeout_err !== (c > TO)) begin
        n_fail++;
        $display("FAIL timeout_err c=%0d got %b exp %b", c,
                 timeout_err, (c > TO));
      end
    end
  endtask

  task automatic test_async_reset();
    int r;
    logic [3:0] ev;
    r = $urandom_range(5, 30);
    for (int c = 0; c <= r; c++) begin
      @(negedge clk);
      set_idle();
      ex_valid = 1'b1; ex_is_md = 1'b1;
      #1;
      ev = {c == 0, 1'b1, 1'b0, c >= 1};
      n_chk++;
      if ({md_valid, stall, res_valid, busy} !== ev) begin
        n_fail++;
        $display("FAIL areset pre c=%0d got %b exp %b", c,
                 {md_valid, stall, res_valid, busy}, ev);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({md_valid, stall, res_valid, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL areset outs got %b exp 0000",
               {md_valid, stall, res_valid, busy});
    end
    n_chk++;
    if ({res_data, md_ctrl, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL areset regs got %h/%h/%b exp 0", res_data,
               md_ctrl, timeout_err);
    end
    exp_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_single();
    test_back_to_back();
    test_flush_nonmd();
    test_flush_md();
    test_flush_ready();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
